// File: rtl/sync_fifo_bram_pkg.sv
// Shared sizing helpers and default thresholds for the block-RAM backed FIFO.
package sync_fifo_bram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int AE_THRESH_DEFAULT  = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // The count also includes the output register, so it needs one bit more than the address.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int af_thresh_default(input int addr_width);
        return fifo_depth(addr_width) - 2;
    endfunction

endpackage

// File: rtl/sync_fifo_bram_sdp_bram.sv
// Simple dual-port RAM with a registered read port, shaped to infer as ECP5 block RAM.
module sdp_bram
    import sync_fifo_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage and rdata have no reset; adding one would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_bram.sv
// First-word-fall-through FIFO; the RAM read register doubles as the output stage.
module sync_fifo_bram
    import sync_fifo_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AF_THRESH  = af_thresh_default(ADDR_WIDTH),
    parameter int AE_THRESH  = AE_THRESH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         mem_count_q, mem_count_d;
    logic                  out_valid_q, out_valid_d;
    logic                  push, rd_en;

    // Full/empty come from mem_count alone, so in_ready never depends on out_ready.
    assign in_ready = (mem_count_q != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign rd_en    = (mem_count_q != '0) & (~out_valid_q | out_ready);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mem_count_d = mem_count_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            mem_count_d = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_d = rptr_q + 1'b1;
            end
            mem_count_d = mem_count_q + CW'(push) - CW'(rd_en);
            out_valid_d = rd_en | (out_valid_q & ~out_ready);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_count_q <= mem_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    // A flushed cycle must leave memory untouched; reads only touch already-written entries.
    sdp_bram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (push & ~flush),
        .waddr(wptr_q),
        .wdata(in_data),
        .re   (rd_en & ~flush),
        .raddr(rptr_q),
        .rdata(out_data)
    );

    assign out_valid    = out_valid_q;
    assign count        = mem_count_q + CW'(out_valid_q);
    assign almost_full  = (int'(count) >= AF_THRESH);
    assign almost_empty = (int'(count) <= AE_THRESH);

endmodule

// File: tb/tb_sync_fifo_bram.sv
// Self-checking bench: queue scoreboard plus a vector table and directed corner sequences.
module tb_sync_fifo_bram;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CAP = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;

    sync_fifo_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] sb[$];
    bit last_push;

    typedef struct {
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        int            exp_count;
        logic          exp_ov;
        logic          exp_ir;
        logic          chk_data;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are already driven; evaluate the handshake at the negedge, then advance one edge.
    task automatic cycle();
        logic [DW-1:0] exp_word;
        @(negedge clk);
        check("count_vs_model", 32'(count), 32'(sb.size()));
        check("in_ready_vs_model", 32'(in_ready), 32'(sb.size() < CAP));
        check("almost_full_vs_model", 32'(almost_full), 32'(sb.size() >= 14));
        check("almost_empty_vs_model", 32'(almost_empty), 32'(sb.size() <= 1));
        last_push = in_valid & in_ready & ~flush;
        if (out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                check("spurious_pop", 32'd1, 32'd0);
            end else begin
                exp_word = sb.pop_front();
                check("pop_data", 32'(out_data), 32'(exp_word));
            end
        end
        if (last_push) sb.push_back(in_data);
        @(posedge clk);
        if (flush) sb.delete();
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int sent;
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        check("reset_count", 32'(count), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_almost_empty", 32'(almost_empty), 32'd1);
        check("reset_almost_full", 32'(almost_full), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty latency and back-to-back streaming through a near-empty FIFO.
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'h11, 1'b1, 1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 8'h22, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'h11};
        vecs[5] = '{1'b1, 8'h33, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'h22};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 1'b1, 8'h33};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h00};
        for (int i = 0; i < 8; i++) begin
            in_valid = vecs[i].iv; in_data = vecs[i].din; out_ready = vecs[i].ordy;
            cycle();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
        end

        // Fill to capacity, then hold an 18th word.
        out_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            cycle();
        end
        check("full_count", 32'(count), 32'd17);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_almost_full", 32'(almost_full), 32'd1);
        in_data = 8'h11;
        for (int i = 0; i < 3; i++) cycle();
        check("full_hold_count", 32'(count), 32'd17);

        // Full with simultaneous pop: first cycle pops only, then one in and one out.
        out_ready = 1'b1;
        cycle();
        check("full_pop_only", 32'(count), 32'd16);
        for (int i = 0; i < 20; i++) begin
            if (last_push) in_data = in_data + 8'd1;
            cycle();
        end
        if (last_push) in_data = in_data + 8'd1;
        drain(100);

        // Wrap: 100 incrementing words with random stalls on both sides.
        sent = 0; n = 0;
        in_valid = 1'b0;
        while ((sent < 100 || sb.size() != 0) && n < 2000) begin
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            in_data   = 8'(sent);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (last_push) sent++;
            n++;
        end
        check("wrap_sent", 32'(sent), 32'd100);
        check("wrap_drained", 32'(sb.size()), 32'd0);
        drain(50);

        // Flush at count=9 together with a push of 0x77.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(i);
            cycle();
        end
        check("preflush_count", 32'(count), 32'd9);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("postflush_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h01;
        cycle();
        in_valid = 1'b0;
        drain(10);

        // Async reset between edges while data is buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h3C;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("post_rst_out_valid", 32'(out_valid), 32'd1);
        check("post_rst_out_data", 32'(out_data), 32'h3C);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
